// File: rtl/bcd_seg_driver.sv
// Six-digit BCD to seven-segment driver with leading-zero blanking
// and a blinking overflow message.
module bcd_seg_driver #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       Rbutton,
  input  logic       load,
  input  logic       lz_blank,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] D4,
  input  logic [3:0] D5,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       err
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] BC_MAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  logic [3:0]    d     [6];
  logic [3:0]    l_q   [6];
  logic [6:0]    hex_q [6];
  logic [6:0]    hex_d [6];
  logic [CW-1:0] bc_q, bc_d;
  logic          ph_q, ph_d;
  logic          err_q, err_d;
  logic          lead;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      4'd10:   s = 7'h06;
      4'd11:   s = 7'h2F;
      4'd12:   s = 7'h23;
      4'd13:   s = 7'h3F;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  assign d[0] = D0;
  assign d[1] = D1;
  assign d[2] = D2;
  assign d[3] = D3;
  assign d[4] = D4;
  assign d[5] = D5;

  always_comb begin
    err_d = (l_q[5] == 4'd10);
    bc_d  = '0;
    ph_d  = 1'b1;
    // Entering error mode falls through to the restart values above
    if (err_d && err_q) begin
      if (bc_q == BC_MAX) begin
        ph_d = ~ph_q;
      end else begin
        bc_d = bc_q + CW'(1);
        ph_d = ph_q;
      end
    end
    lead = 1'b1;
    for (int k = 5; k >= 0; k--) begin
      lead     = lead && (l_q[k] == 4'd0);
      hex_d[k] = seg(l_q[k]);
      if (lz_blank && !err_d && k != 0 && lead)
        hex_d[k] = BLANK;
      if (err_d && !ph_d)
        hex_d[k] = BLANK;
    end
  end

  always_ff @(posedge clk or negedge Rbutton) begin
    if (!Rbutton) begin
      for (int k = 0; k < 6; k++) begin
        l_q[k]   <= '0;
        hex_q[k] <= BLANK;
      end
      bc_q  <= '0;
      ph_q  <= 1'b1;
      err_q <= 1'b0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (load)
          l_q[k] <= d[k];
        hex_q[k] <= hex_d[k];
      end
      bc_q  <= bc_d;
      ph_q  <= ph_d;
      err_q <= err_d;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Randomized self-checking bench for bcd_seg_driver against an
// elapsed-time behavioural model of the display.
module tb_bcd_seg_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       Rbutton;
  logic       load;
  logic       lz_blank;
  logic [3:0] D [6];
  logic [6:0] HEX [6];
  logic       err;

  int npass = 0;
  int ntot  = 0;

  bcd_seg_driver #(.BLINK_DIV(DIV)) dut (
    .clk(clk), .Rbutton(Rbutton), .load(load), .lz_blank(lz_blank),
    .D0(D[0]), .D1(D[1]), .D2(D[2]), .D3(D[3]), .D4(D[4]), .D5(D[5]),
    .HEX0(HEX[0]), .HEX1(HEX[1]), .HEX2(HEX[2]),
    .HEX3(HEX[3]), .HEX4(HEX[4]), .HEX5(HEX[5]),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
  endtask

  // Model: table lookup plus cycles elapsed since error entry
  logic [6:0] tbl [16];
  initial begin
    tbl[0] = 7'h40; tbl[1] = 7'h79; tbl[2] = 7'h24; tbl[3] = 7'h30;
    tbl[4] = 7'h19; tbl[5] = 7'h12; tbl[6] = 7'h02; tbl[7] = 7'h78;
    tbl[8] = 7'h00; tbl[9] = 7'h10; tbl[10] = 7'h06; tbl[11] = 7'h2F;
    tbl[12] = 7'h23; tbl[13] = 7'h3F; tbl[14] = 7'h7F; tbl[15] = 7'h7F;
  end

  int         mL [6];
  bit         merr;
  int         ecnt;
  logic [6:0] eh [6];
  bit         eerr;
  bit         en_, vis, lead;

  always @(posedge clk or negedge Rbutton) begin
    if (!Rbutton) begin
      for (int k = 0; k < 6; k++) begin
        mL[k] = 0;
        eh[k] = 7'h7F;
      end
      merr = 0; eerr = 0; ecnt = 0;
    end else begin
      en_ = (mL[5] == 10);
      if (en_) ecnt = merr ? ecnt + 1 : 0;
      else ecnt = 0;
      vis  = ((ecnt / DIV) % 2) == 0;
      lead = 1;
      for (int k = 5; k >= 0; k--) begin
        lead = lead && (mL[k] == 0);
        if (en_ && !vis) eh[k] = 7'h7F;
        else if (lz_blank && !en_ && k > 0 && lead) eh[k] = 7'h7F;
        else eh[k] = tbl[mL[k]];
      end
      merr = en_;
      eerr = en_;
      if (load)
        for (int k = 0; k < 6; k++) mL[k] = int'(D[k]);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 6; k++)
      chk($sformatf("model_hex%0d", k), {1'b0, HEX[k]}, {1'b0, eh[k]});
    chk("model_err", {7'b0, err}, {7'b0, eerr});
  end

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setd(input int d5, d4, d3, d2, d1, d0);
    D[5] = 4'(d5); D[4] = 4'(d4); D[3] = 4'(d3);
    D[2] = 4'(d2); D[1] = 4'(d1); D[0] = 4'(d0);
  endtask

  initial begin
    Rbutton = 1'b1; load = 1'b0; lz_blank = 1'b0;
    setd(0, 0, 0, 0, 0, 0);
    #2 Rbutton = 1'b0;
    nedge(2);
    chk("rst_hex5", {1'b0, HEX[5]}, 8'h7F);
    chk("rst_hex0", {1'b0, HEX[0]}, 8'h7F);
    chk("rst_err", {7'b0, err}, 8'h00);
    Rbutton = 1'b1;
    nedge(1);
    chk("rel_hex3", {1'b0, HEX[3]}, 8'h40);

    setd(9, 8, 7, 6, 5, 4); load = 1'b1;
    nedge(1); load = 1'b0;
    chk("dec_early", {1'b0, HEX[5]}, 8'h40);
    nedge(1);
    chk("dec_hex5", {1'b0, HEX[5]}, 8'h10);
    chk("dec_hex4", {1'b0, HEX[4]}, 8'h00);
    chk("dec_hex3", {1'b0, HEX[3]}, 8'h78);
    chk("dec_hex0", {1'b0, HEX[0]}, 8'h19);

    setd(0, 0, 1, 0, 0, 7); load = 1'b1; lz_blank = 1'b1;
    nedge(1); load = 1'b0;
    nedge(1);
    chk("lz_hex5", {1'b0, HEX[5]}, 8'h7F);
    chk("lz_hex3", {1'b0, HEX[3]}, 8'h79);
    chk("lz_hex1", {1'b0, HEX[1]}, 8'h40);
    setd(0, 0, 0, 0, 0, 0); load = 1'b1;
    nedge(2); load = 1'b0;
    chk("lz0_hex1", {1'b0, HEX[1]}, 8'h7F);
    chk("lz0_hex0", {1'b0, HEX[0]}, 8'h40);

    setd(10, 11, 11, 12, 11, 13); load = 1'b1;
    nedge(1); load = 1'b0;
    nedge(1);
    chk("em_err", {7'b0, err}, 8'h01);
    chk("em_hex5", {1'b0, HEX[5]}, 8'h06);
    chk("em_hex2", {1'b0, HEX[2]}, 8'h23);
    chk("em_hex0", {1'b0, HEX[0]}, 8'h3F);
    nedge(3);
    chk("em_vis4", {1'b0, HEX[5]}, 8'h06);
    nedge(1);
    chk("em_blank", {1'b0, HEX[5]}, 8'h7F);
    nedge(4);
    chk("em_vis2", {1'b0, HEX[4]}, 8'h2F);
    nedge(4);
    chk("em_blank2", {1'b0, HEX[2]}, 8'h7F);
    setd(0, 0, 0, 0, 0, 1); load = 1'b1; lz_blank = 1'b0;
    nedge(1); load = 1'b0;
    nedge(1);
    chk("ex_err", {7'b0, err}, 8'h00);
    chk("ex_hex0", {1'b0, HEX[0]}, 8'h79);
    chk("ex_hex1", {1'b0, HEX[1]}, 8'h40);
    nedge(6);
    chk("ex_stay", {1'b0, HEX[1]}, 8'h40);

    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 9) == 0);
      if (i % 8 == 0) lz_blank = 1'($urandom_range(0, 1));
      D[5] = ($urandom_range(0, 2) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      for (int k = 0; k < 5; k++)
        D[k] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      nedge(1);
    end

    setd(10, 11, 11, 12, 11, 13); load = 1'b1;
    nedge(1); load = 1'b0;
    nedge(7);
    #2 Rbutton = 1'b0;
    #1;
    chk("ar_hex5", {1'b0, HEX[5]}, 8'h7F);
    chk("ar_hex0", {1'b0, HEX[0]}, 8'h7F);
    chk("ar_err", {7'b0, err}, 8'h00);
    nedge(1);
    Rbutton = 1'b1;
    nedge(3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/bcd_seg_driver.md
# bcd_seg_driver

Display-side consumer for the six-digit BCD stopwatch count. Latches six 4-bit digit codes (values 0-9, plus overflow codes 10-13 that spell an error message) on a load strobe. Decodes them to six active-low seven-segment patterns for HEX0-HEX5, with optional leading-zero blanking. When the latched value is an overflow message, all six displays blink at a rate set by an internal prescaler.

## Interface
Parameters:
- BLINK_DIV, default 25000000 — clk cycles per blink half-period; legal range ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- Rbutton  in  1  asynchronous, active-low reset.
- load  in  1  when 1 at a rising edge, D0-D5 are captured.
- lz_blank  in  1  enables leading-zero blanking; sampled every cycle, not latched.
- D0..D5  in  4 each  digit codes; D0 is the least significant.
- HEX0..HEX5  out  7 each  registered segments, active-low, bit order {g,f,e,d,c,b,a}.
- err  out  1  registered; 1 while the latched D5 == 10.

## Operation
- **Digit latch**
  - L0..L5 hold the captured digits.
  - Load rule: if load=1 at an edge, Lk <= Dk; otherwise Lk holds.
- **Decode table** (7-bit hex values, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - 10='E'=06, 11='r'=2F, 12='o'=23, 13='-'=3F
  - 14 and 15 are blank=7F.
- **Error mode**
  - Condition: err_next = (L5 == 10).
  - In error mode, leading-zero blanking is ignored.
- **Leading-zero blanking** (only when lz_blank=1 and not in error mode):
  - Digit k (k=5..1) is blank (7F) if Lk and every Lj with j>k equal 0.
  - HEX0 is never blanked.
- **Blink machine**
  - State: counter bc (width clog2(BLINK_DIV)) and phase bit ph (1=visible).
  - Not in error mode: bc=0, ph=1.
  - In error mode, each cycle:
    - if bc == BLINK_DIV-1, then bc <= 0 and ph <= ~ph;
    - else bc <= bc+1.
  - On entering error mode (err_next=1 while err=0), bc restarts at 0 and ph=1, so the message is visible first.
  - On leaving error mode, bc <= 0 and ph <= 1 at that same edge.
- **Output stage**
  - Each edge: HEXk <= (err_next && !ph_next) ? 7F : blanked decode of Lk.
  - ph_next is the value ph takes at that edge.
  - err <= err_next.
- **Reset** (Rbutton=0, asynchronous):
  - L0-L5 = 0; HEX0-HEX5 = 7F; err = 0; bc = 0; ph = 1.
  - Release is synchronous to the next edge.
  - Reset asserted mid-blink aborts the blink immediately.

## Timing
- Load-to-display latency is 2 edges.
  - Edge N with load=1 updates L.
  - Edge N+1 updates HEX and err.
- lz_blank change is visible on HEX after 1 edge.
- Blink period = 2*BLINK_DIV cycles, 50% duty.
  - First visible half-period counts from the edge that sets err=1.
  - That half-period is exactly BLINK_DIV cycles.
- load may be held high continuously; HEX then tracks D with 2-edge latency.
- Simultaneous load and blink-counter wrap: the wrap is evaluated on the pre-load L.
  - The new L takes effect in the next cycle's error check.
- No handshake and no backpressure: the producer may present new digits every cycle.

## Test plan
(Simulations run with BLINK_DIV=4.)
- **Reset:** hold Rbutton=0 → HEX0-5=7F, err=0. Release with D=0 and load=0 → after 1 edge, HEX0-5=40 (lz_blank=0).
- **Decimal decode:** load D5..D0 = 9,8,7,6,5,4 at edge N → HEX5..HEX0 = 10,00,78,02,12,19 at edge N+1, not before.
- **Leading-zero blanking:** L = 0,0,1,0,0,7 (D5..D0), lz_blank=1 → HEX5,HEX4=7F; HEX3=79; HEX2,HEX1=40; HEX0=78. Load all zeros → only HEX0=40.
- **Error message:** load D5..D0 = 10,11,11,12,11,13.
  - err=1; HEX = 06,2F,2F,23,2F,3F for 4 cycles; then all 7F for 4 cycles; repeating.
  - lz_blank=1 has no effect.
- **Error exit mid-blink:** during a blanked phase, load 0,0,0,0,0,1 → next edge: err=0, HEX0=79, no blank phase afterward.
- **Async reset mid-error:** assert Rbutton between edges → outputs go to 7F and err=0 before the next edge.
